// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag bundle for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_NAND = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_MUL  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        MUL_BUSY,
        MUL_DONE
    } state_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational core for every single-cycle opcode and its carry/overflow.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       command,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic             add_ov;
    logic             sub_ov;
    logic [SHW-1:0]   sh;

    assign sh     = b[SHW-1:0];
    assign add_s  = {1'b0, a} + {1'b0, b};
    assign sub_s  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (add_s[WIDTH-1] != a[WIDTH-1]);
    assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) &&
                    (sub_s[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (command)
            ALU_ADD: begin
                result   = add_s[WIDTH-1:0];
                carryout = add_s[WIDTH];
                overflow = add_ov;
            end
            ALU_SUB: begin
                result   = sub_s[WIDTH-1:0];
                carryout = sub_s[WIDTH];
                overflow = sub_ov;
            end
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_ov};
            ALU_AND:  result = a & b;
            ALU_NAND: result = ~(a & b);
            ALU_NOR:  result = ~(a | b);
            ALU_OR:   result = a | b;
            ALU_SLL:  result = a << sh;
            ALU_SRL:  result = a >> sh;
            ALU_SRA:  result = $signed(a) >>> sh;
            // MUL is produced by the sequential datapath; reserved codes give 0
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and a shift-add multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   core_res;
    logic               core_c;
    logic               core_o;
    logic               accept;
    logic               is_mul;
    logic               load_mul;

    alu_comb #(.WIDTH(WIDTH)) u_core (
        .a        (a),
        .b        (b),
        .command  (command),
        .result   (core_res),
        .carryout (core_c),
        .overflow (core_o)
    );

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (command == ALU_MUL);
    // The product may only land once the output slot is free or draining
    assign load_mul = (state_q == MUL_DONE) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == LAST) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                if (load_mul) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept && !is_mul) begin
            result_d         = core_res;
            flags_d.carry    = core_c;
            flags_d.overflow = core_o;
            flags_d.zero     = (core_res == '0);
            out_valid_d      = 1'b1;
        end else if (load_mul) begin
            result_d         = acc_q[WIDTH-1:0];
            flags_d.carry    = 1'b0;
            flags_d.overflow = |acc_q[2*WIDTH-1:WIDTH];
            flags_d.zero     = (acc_q[WIDTH-1:0] == '0);
            out_valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryout  = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   command;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;

    int checks = 0;
    int failures = 0;
    int drains = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .command   (command),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) drains++;
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] cmd,
                         input logic [W-1:0] aa,
                         input logic [W-1:0] bb);
        int n;
        @(negedge clk);
        command  = cmd;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic single(input string tag,
                          input logic [3:0] cmd,
                          input logic [W-1:0] aa,
                          input logic [W-1:0] bb,
                          input logic [W-1:0] er,
                          input logic [2:0] ef);
        issue(cmd, aa, bb);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_flags"}, 64'({carryout, overflow, zero}), 64'(ef));
    endtask

    task automatic mul(input string tag,
                       input logic [W-1:0] aa,
                       input logic [W-1:0] bb,
                       input logic [W-1:0] er,
                       input logic [2:0] ef);
        int n;
        logic ir_seen;
        issue(ALU_MUL, aa, bb);
        n = 0;
        ir_seen = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            ir_seen |= in_ready;
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 64'(n), 64'(W + 1));
        chk({tag, "_busy_ready"}, 64'(ir_seen), 64'(0));
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_flags"}, 64'({carryout, overflow, zero}), 64'(ef));
    endtask

    initial begin
        logic spur;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        command   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_flags", 64'({carryout, overflow, zero}), 64'(0));
        rst_n = 1'b1;
        #1 chk("rst_ready", 64'(in_ready), 64'(1));

        // flags are {carry, overflow, zero}
        single("add", ALU_ADD, 32'd2147483647, 32'd14000,
               32'd2147497647, 3'b010);
        single("sub_eq", ALU_SUB, 32'd3657483652, 32'd3657483652,
               32'd0, 3'b101);
        single("sub_neg", ALU_SUB, 32'd0, 32'd637483644,
               32'd3657483652, 3'b000);
        single("slt", ALU_SLT, 32'd3657483652, 32'd1000,
               32'd1, 3'b000);
        single("sra", ALU_SRA, 32'h8000_0000, 32'd4,
               32'hF800_0000, 3'b000);
        single("sll", ALU_SLL, 32'd1, 32'd31,
               32'h8000_0000, 3'b000);

        mul("mul_a", 32'd7000, 32'd14000, 32'd98000000, 3'b000);
        mul("mul_b", 32'h0001_0000, 32'h0001_0000, 32'd0, 3'b011);

        issue(ALU_OR, 32'd12, 32'd10);
        out_ready = 1'b0;
        @(negedge clk);
        command  = ALU_ADD;
        a        = 32'd1;
        b        = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_result", 64'(result), 64'(14));
            chk("bp_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp2_valid", 64'(out_valid), 64'(1));
        chk("bp2_result", 64'(result), 64'(3));
        chk("drains_bp", 64'(drains), 64'(9));

        issue(ALU_MUL, 32'd7000, 32'd14000);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'(0));
        chk("mrst_result", 64'(result), 64'(0));
        chk("mrst_flags", 64'({carryout, overflow, zero}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mrst_ready", 64'(in_ready), 64'(1));
        spur = 1'b0;
        repeat (40) begin
            @(negedge clk);
            spur |= out_valid;
        end
        chk("mrst_spurious", 64'(spur), 64'(0));

        single("srl", ALU_SRL, 32'h0000_00F0, 32'd4,
               32'h0000_000F, 3'b000);
        single("xor", ALU_XOR, 32'h0000_FF00, 32'h0000_0FF0,
               32'h0000_F0F0, 3'b000);
        single("nand", ALU_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'd0, 3'b001);
        single("rsvd", 4'b1101, 32'd5, 32'd5, 32'd0, 3'b001);
        @(posedge clk);
        #1 chk("drains_total", 64'(drains), 64'(14));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor of the team's 32-bit combinational ALU. It adds a valid/ready handshake on both sides, a registered output stage with backpressure, shift ops and a multi-cycle unsigned shift-add multiplier.
- Sits between the operand fetch stage and writeback in the lab CPU datapath.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >= 8)
SHW, $clog2(WIDTH), localparam: shift-amount width taken from b[SHW-1:0]

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/command valid
in_ready  out  1  block can accept this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
command  in  4  opcode (see Behaviour)
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
carryout  out  1  registered carry flag
overflow  out  1  registered overflow flag
zero  out  1  registered zero flag, 1 iff result==0

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, result=0, carryout=0, overflow=0, zero=0, state=IDLE, in_ready=1 after reset release.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 SLT, 0100 AND, 0101 NAND, 0110 NOR, 0111 OR.
  - 1000 SLL, 1001 SRL, 1010 SRA (shift a by b[SHW-1:0]).
  - 1011 MUL, low WIDTH bits of unsigned a*b.
  - 11xx reserved: result=0, zero=1, carryout=0, overflow=0.
- Handshake:
  - Acceptance edge = rising edge with in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - The output drains when out_valid && out_ready. result and the flags hold stable while out_valid && !out_ready.
- FSM states:
  - IDLE to IDLE on single-cycle op accept.
  - IDLE to MUL_BUSY on MUL accept.
  - MUL_BUSY to MUL_DONE after WIDTH iterations.
  - MUL_DONE to IDLE when the output register loads.
- Single-cycle ops:
  - Computed from a/b/command at the acceptance edge and loaded into the output register on that edge.
  - out_valid=1 in the next cycle (latency 1).
  - Back-to-back accepts at full throughput when out_ready=1.
- ADD:
  - result = a+b mod 2^WIDTH; carryout = bit WIDTH of the sum.
  - overflow = signed overflow (operand signs equal, result sign differs).
- SUB:
  - Computed as a + ~b + 1; carryout = carry of that sum (1 iff a >= b unsigned; 0-p gives 0, p-p gives 1).
  - overflow = signed overflow (operand signs differ, result sign differs from a).
- Other ops: carryout=0 and overflow=0 for all ops except ADD/SUB/MUL.
- SLT: result = {0..., signed(a) < signed(b)}, derived from the SUB sign XOR SUB overflow.
- Shifts: SRA sign-extends; shift amount 0 returns a unchanged.
- MUL:
  - Acceptance edge E0 latches a, b and clears a 2*WIDTH accumulator and the counter.
  - Edges E1..E_WIDTH each perform one shift-add iteration.
  - Edge E_WIDTH+1 (MUL_DONE) loads the output: result = product[WIDTH-1:0], overflow = |product[2W-1:W], carryout=0.
  - in_ready=0 from E0 until the output drains.
  - If out_valid is still held from a prior op when MUL_DONE is reached, the FSM stays in MUL_DONE until out_ready drains the output register, then loads.
- zero is computed from the final registered result for every op.
- Reset mid-operation: asserting rst_n=0 during MUL_BUSY/MUL_DONE aborts immediately. The accumulator result is discarded and no out_valid pulse follows reset.
- in_valid without in_ready: inputs are ignored; the source must hold them (no internal input buffer).

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (ALU_ADD..ALU_MUL).
  - FSM state encoding (IDLE, MUL_BUSY, MUL_DONE).
  - Flag bundle ordering.
- Sub-module alu_comb: a parametrised combinational core covering the single-cycle ops and flags.
- alu_pipe instantiates alu_comb and owns the FSM, multiplier datapath and output register.

Test Plan:
- ADD, out_ready=1: a=2147483647, b=14000 -> one cycle later out_valid=1, result=2147497647, overflow=1, carryout=0, zero=0.
- SUB: a=b=3657483652 -> result=0, zero=1, carryout=1, overflow=0. Then a=0, b=637483644 -> result=3657483652, carryout=0.
- SLT and shifts: a=3657483652, b=1000 -> result=1. SRA with a=0x80000000, b=4 -> 0xF8000000. SLL with a=1, b=31 -> 0x80000000.
- MUL: a=7000, b=14000 -> in_ready=0 for WIDTH+1 edges, then result=98000000, overflow=0. Then a=0x10000, b=0x10000 -> result=0, zero=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after an OR (a=12, b=10) -> result=14 stable and in_ready=0. A second request is accepted only in the cycle out_ready=1. No result is lost or duplicated.
- Reset mid-MUL: pull rst_n low at iteration 10 -> all outputs 0 immediately. After release in_ready=1 and no spurious out_valid.
